spectro_frame_reader: RTL

Parametrised successor to the spectrometer FIFO drain stage. It pulls ADC samples from an external standard-mode (non-FWFT) FIFO with configurable read latency and buffers them locally, so a downstream valid/ready consumer can stall without losing data. It groups samples into fixed-length spectra with start/end-of-frame markers and a frame counter. It sits between the ADC capture FIFO and the spectrum packetiser, and stops only on frame boundaries.

---
 rtl/spectro_pkg.sv | 22 ++
 rtl/spectro_sync_fifo.sv | 70 +++++++
 rtl/spectro_frame_reader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/spectro_pkg.sv
// Shared types and width helpers for the spectrometer readout blocks.
package spectro_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam int unsigned FRAME_CNT_W = 16;

  // Bits needed for an index ranging over 0..n-1.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed for a count ranging over 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spectro_sync_fifo.sv
// Register-based first-word-fall-through FIFO with occupancy output.
// The head value is held after the last read so rd_data never shows stale slots.
module spectro_sync_fifo
  import spectro_pkg::*;
#(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = idx_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              pop;

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = empty ? last_q : mem_q[rd_ptr_q];
  assign pop     = rd_en && !empty;

  // A write into the slot being read while full is safe: the read uses the pre-edge value.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/spectro_frame_reader.sv
// Drains a standard-mode ADC FIFO into a local buffer and emits fixed-length
// spectra with sof/eof markers; streaming only ever stops on a frame boundary.
module spectro_frame_reader
  import spectro_pkg::*;
#(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned FRAME_LEN  = 2048,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BUF_DEPTH  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ENABLE,
  input  logic [DATA_W-1:0]      fifoData,
  input  logic                   FIFO_EMPTY,
  output logic                   FIFO_RD,
  output logic [DATA_W-1:0]      dataOut,
  output logic                   dataValid,
  input  logic                   dataReady,
  output logic                   sof,
  output logic                   eof,
  output logic [FRAME_CNT_W-1:0] frameCount,
  output logic                   busy
);

  localparam int unsigned IDX_W = idx_w(FRAME_LEN);
  localparam int unsigned OCC_W = cnt_w(BUF_DEPTH);
  localparam int unsigned INF_W = cnt_w(RD_LATENCY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e                 state_q, state_d;
  logic                   stop_q, stop_d;
  logic [IDX_W-1:0]       issue_idx_q, issue_idx_d;
  logic [IDX_W-1:0]       out_idx_q, out_idx_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [INF_W-1:0]       inflight_q, inflight_d;
  logic [RD_LATENCY-1:0]  land_sr_q, land_sr_d;

  logic             buf_empty;
  logic [OCC_W-1:0] occ;
  logic             land, xfer, credit, stop_req, stop_now, fifo_rd, drain_done;

  spectro_sync_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .CLK    (CLK),
    .RST    (RST),
    .wr_en  (land),
    .wr_data(fifoData),
    .rd_en  (dataReady),
    .rd_data(dataOut),
    .empty  (buf_empty),
    .count  (occ)
  );

  assign land       = land_sr_q[RD_LATENCY-1];
  assign dataValid  = !buf_empty;
  assign xfer       = dataValid && dataReady;
  assign sof        = (out_idx_q == '0);
  assign eof        = (out_idx_q == LAST_IDX);
  assign frameCount = frame_cnt_q;
  assign busy       = (state_q != IDLE);
  assign FIFO_RD    = fifo_rd;

  assign credit   = (32'(occ) + 32'(inflight_q)) < BUF_DEPTH;
  assign stop_req = stop_q || !ENABLE;
  assign stop_now = stop_req && (issue_idx_q == '0);
  assign fifo_rd  = !RST && (state_q == STREAM) && !FIFO_EMPTY && credit && !stop_now;
  // Done when nothing is in flight and the buffer empties at this edge.
  assign drain_done = (inflight_q == '0) && (occ == OCC_W'(xfer));

  always_comb begin
    state_d     = state_q;
    stop_d      = 1'b0;
    land_sr_d   = RD_LATENCY'({land_sr_q, fifo_rd});
    inflight_d  = inflight_q + INF_W'(fifo_rd) - INF_W'(land);
    issue_idx_d = issue_idx_q;
    out_idx_d   = out_idx_q;
    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(xfer && eof);

    if (fifo_rd) issue_idx_d = (issue_idx_q == LAST_IDX) ? '0 : issue_idx_q + IDX_W'(1);
    if (xfer)    out_idx_d   = (out_idx_q == LAST_IDX) ? '0 : out_idx_q + IDX_W'(1);

    unique case (state_q)
      IDLE: begin
        if (ENABLE) state_d = STREAM;
      end
      STREAM: begin
        stop_d = stop_req;
        if (stop_now || (fifo_rd && issue_idx_q == LAST_IDX && stop_req)) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      stop_q      <= 1'b0;
      land_sr_q   <= '0;
      inflight_q  <= '0;
      issue_idx_q <= '0;
      out_idx_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stop_q      <= stop_d;
      land_sr_q   <= land_sr_d;
      inflight_q  <= inflight_d;
      issue_idx_q <= issue_idx_d;
      out_idx_q   <= out_idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule
